// File: rtl/divider_control_if.sv
// divider_control_if: control/status bundle between the divider sequencer and
// its datapath (Divisor register, 2*WIDTH Remainder register, subtractor).
//
// Handshake: `start` is a request with no separate ready. The sequencer
// accepts it on a rising edge where busy=0 and done=0 (the idle cycle).
// A request seen at any other time is dropped, not queued. Completion is the
// single-cycle `done` pulse.
interface divider_control_if #(
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(WIDTH) + 1;

    // requests / datapath status into the sequencer
    logic          start;
    logic          divisor_zero;
    logic          alu_neg;

    // sequencer status and datapath controls
    logic          busy;
    logic          done;
    logic          dbz;
    logic          w_ctrl_reg1;
    logic          w_ctrl_rem;
    logic          rem_shl;
    logic          rem_q_bit;
    logic          rem_hi_wr;
    logic          rem_hi_shr;
    logic          alu_sub;
    logic [IW-1:0] iter;

    // datapath / requester side
    modport master (
        output start, divisor_zero, alu_neg,
        input  busy, done, dbz, w_ctrl_reg1, w_ctrl_rem, rem_shl, rem_q_bit,
               rem_hi_wr, rem_hi_shr, alu_sub, iter
    );

    // sequencer side
    modport slave (
        input  start, divisor_zero, alu_neg,
        output busy, done, dbz, w_ctrl_reg1, w_ctrl_rem, rem_shl, rem_q_bit,
               rem_hi_wr, rem_hi_shr, alu_sub, iter
    );
endinterface

// File: rtl/divider_control.sv
// divider_control: sequencing FSM for an unsigned restoring shift-subtract
// divider. One quotient bit per cycle, WIDTH iterations, then a final
// right shift of the Remainder upper half. Holds no operand data.
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   -> CHECK state tests divisor_zero and ends early with sticky dbz
//   undefined -> LOAD goes straight to SHIFT0, dbz tied 0
module divider_control #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    divider_control_if.slave    bus,
    output logic [2:0]          o_dbg_state
);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);
    localparam logic [IW-1:0] FULL_ITER = IW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_SHIFT0 = 3'd3,
        S_ITER   = 3'd4,
        S_FIX    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_iter;
    logic          w_accept;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign o_dbg_state = r_state;
    assign bus.iter    = r_iter;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Iteration counter: cleared on an accepted start, counts ITER cycles,
    // saturates at WIDTH and then holds until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter <= '0;
        end else if (w_accept) begin
            r_iter <= '0;
        end else if ((r_state == S_ITER) && (r_iter != FULL_ITER)) begin
            r_iter <= r_iter + 1'b1;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic r_dbz;

    // Sticky divide-by-zero flag: set on leaving CHECK with a zero divisor,
    // cleared only by the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= 1'b0;
        end else if ((r_state == S_CHECK) && bus.divisor_zero) begin
            r_dbz <= 1'b1;
        end
    end

    assign bus.dbz = r_dbz;
`else
    logic w_unused_divisor_zero;

    assign w_unused_divisor_zero = bus.divisor_zero;
    assign bus.dbz               = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef DIV_ZERO_CHECK_EN
                w_next = S_CHECK;
`else
                w_next = S_SHIFT0;
`endif
            end
            S_CHECK: begin
`ifdef DIV_ZERO_CHECK_EN
                w_next = bus.divisor_zero ? S_DONE : S_SHIFT0;
`else
                w_next = S_SHIFT0;
`endif
            end
            S_SHIFT0: begin
                w_next = S_ITER;
            end
            S_ITER: begin
                if (r_iter == LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Control outputs: Moore per state, except the ITER quotient bit and
    // upper-half write which follow the subtractor sign in the same cycle.
    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.w_ctrl_reg1 = 1'b0;
        bus.w_ctrl_rem  = 1'b0;
        bus.rem_shl     = 1'b0;
        bus.rem_q_bit   = 1'b0;
        bus.rem_hi_wr   = 1'b0;
        bus.rem_hi_shr  = 1'b0;
        bus.alu_sub     = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.busy        = 1'b1;
                bus.w_ctrl_reg1 = 1'b1;
                bus.w_ctrl_rem  = 1'b1;
            end
            S_CHECK: begin
                bus.busy = 1'b1;
            end
            S_SHIFT0: begin
                bus.busy    = 1'b1;
                bus.rem_shl = 1'b1;
            end
            S_ITER: begin
                bus.busy      = 1'b1;
                bus.alu_sub   = 1'b1;
                bus.rem_shl   = 1'b1;
                bus.rem_q_bit = ~bus.alu_neg;
                bus.rem_hi_wr = ~bus.alu_neg;
            end
            S_FIX: begin
                bus.busy       = 1'b1;
                bus.rem_hi_shr = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_divider_control.sv
// tb_divider_control: pairs divider_control with a behavioural divider
// datapath and checks every control output each cycle against a
// cycle-schedule model, plus final quotient/remainder against / and %.
module tb_divider_control;
    localparam int W  = 32;
    localparam int IW = $clog2(W) + 1;
`ifdef DIV_ZERO_CHECK_EN
    localparam bit EN = 1'b1;
    localparam int LAT_100_7 = 36;
`else
    localparam bit EN = 1'b0;
    localparam int LAT_100_7 = 35;
`endif
    // cycle offset (edges after the accepting edge) of the first shift
    localparam int S0  = EN ? 2 : 1;
    localparam int LAT = S0 + W + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     dbg_state;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   dp_div = '0;
    logic [2*W-1:0] dp_rem = '0;
    logic [W-1:0]   rem_hi;
    logic [W-1:0]   rem_lo;
    logic [W-1:0]   hi_next;
    logic           start_zero;
    int             total = 0;
    int             bad = 0;

    divider_control_if #(.WIDTH(W)) bus ();

    divider_control #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    assign rem_hi           = dp_rem[2*W-1:W];
    assign rem_lo           = dp_rem[W-1:0];
    assign bus.divisor_zero = (dp_div == '0);
    assign bus.alu_neg      = (rem_hi < dp_div);
    assign hi_next          = bus.rem_hi_wr ? (rem_hi - dp_div) : rem_hi;

    always @(posedge clk) begin
        if (bus.w_ctrl_reg1) dp_div <= op_b;
        if (bus.w_ctrl_rem)
            dp_rem <= {{W{1'b0}}, op_a};
        else if (bus.rem_shl)
            dp_rem <= {hi_next[W-2:0], rem_lo, bus.rem_q_bit};
        else if (bus.rem_hi_shr)
            dp_rem <= {1'b0, rem_hi[W-1:1], rem_lo};
    end

    // ---------------- controller model: cycle schedule ----------------
    bit m_active;
    int m_p;
    int m_done_p;
    bit m_zero;
    bit m_dbz;
    int m_iter_hold;

    assign start_zero = EN && (op_b == '0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_p <= 0; m_done_p <= 0;
            m_zero <= 1'b0; m_dbz <= 1'b0; m_iter_hold <= 0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active    <= 1'b1;
                m_p         <= 0;
                m_zero      <= start_zero;
                m_dbz       <= 1'b0;
                m_iter_hold <= 0;
                m_done_p    <= start_zero ? 2 : LAT;
            end
        end else if (m_p == m_done_p) begin
            m_active    <= 1'b0;
            m_iter_hold <= m_zero ? 0 : W;
        end else begin
            m_p <= m_p + 1;
            if (m_zero && (m_p + 1 == m_done_p)) m_dbz <= 1'b1;
        end
    end

    // Compare all controller outputs against the model every cycle.
    always @(negedge clk) begin
        bit run;
        bit it;
        int e_iter;
        run = m_active && !m_zero;
        it  = run && (m_p > S0) && (m_p <= S0 + W);
        if (it)                          e_iter = m_p - S0 - 1;
        else if (run && m_p > S0 + W)    e_iter = W;
        else if (m_active)               e_iter = 0;
        else                             e_iter = m_iter_hold;
        check("busy",   bus.busy,        m_active && (m_p != m_done_p));
        check("done",   bus.done,        m_active && (m_p == m_done_p));
        check("reg1",   bus.w_ctrl_reg1, m_active && (m_p == 0));
        check("remld",  bus.w_ctrl_rem,  m_active && (m_p == 0));
        check("shl",    bus.rem_shl,     run && (m_p >= S0) && (m_p <= S0 + W));
        check("qbit",   bus.rem_q_bit,   it && !bus.alu_neg);
        check("hiwr",   bus.rem_hi_wr,   it && !bus.alu_neg);
        check("hishr",  bus.rem_hi_shr,  run && (m_p == S0 + W + 1));
        check("alusub", bus.alu_sub,     it);
        check("iter",   bus.iter,        e_iter);
        check("dbz",    bus.dbz,         m_dbz);
        check("idle",   dbg_state == 3'd0, !m_active);
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input int rst_at, input bit hold,
                          output int done_at, output int shl_cnt,
                          output logic [2*W-1:0] res);
        done_at = -1; shl_cnt = 0; res = '0;
        @(negedge clk); #1;
        op_a = a; op_b = b; bus.start = 1'b1;
        for (int p = 0; p < 3 * W; p++) begin
            @(negedge clk); #1;
            if (!hold) bus.start = (p == pulse_at);
            if (bus.rem_shl) shl_cnt++;
            if (p == rst_at) begin
                rst = 1'b1; #1;
                check("rst_busy", bus.busy, 1'b0);
                check("rst_done", bus.done, 1'b0);
                check("rst_shl",  bus.rem_shl, 1'b0);
                check("rst_iter", bus.iter, 0);
                @(negedge clk); #1;
                rst = 1'b0;
                repeat (4) @(negedge clk);
                return;
            end
            if (bus.done) begin
                done_at = p; res = dp_rem;
                break;
            end
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        check("done_seen", done_at >= 0, 1'b1);
    endtask

    initial begin
        int d;
        int s;
        logic [2*W-1:0] r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst = 1'b1; bus.start = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_dbz",  bus.dbz,  1'b0);
        check("reset_iter", bus.iter, 0);
        rst = 1'b0;

        run_op(100, 7, -1, -1, 1'b0, d, s, r);
        check("lat_100_7", d, LAT_100_7);
        check("q_100_7",   r[W-1:0], 14);
        check("r_100_7",   r[2*W-1:W], 2);
        check("shl_100_7", s, 33);
        check("dbz_100_7", bus.dbz, 1'b0);

        run_op(32'hFFFF_FFFF, 1, -1, -1, 1'b0, d, s, r);
        check("q_ff_1", r[W-1:0], 32'hFFFF_FFFF);
        check("r_ff_1", r[2*W-1:W], 0);

        run_op(32'h1234_5678, 32'hABCD_EF01, -1, -1, 1'b0, d, s, r);
        check("q_big", r[W-1:0], 0);
        check("r_big", r[2*W-1:W], 32'h1234_5678);

        run_op(32'h1234_5678, 0, -1, -1, 1'b0, d, s, r);
`ifdef DIV_ZERO_CHECK_EN
        check("lat_dbz", d, 2);
        check("shl_dbz", s, 0);
        check("rem_dbz", r, {32'h0, 32'h1234_5678});
        check("dbz_set", bus.dbz, 1'b1);
`else
        check("lat_z",  d, 35);
        check("q_z",    r[W-1:0], 32'hFFFF_FFFF);
        check("r_z",    r[2*W-1:W], 32'h1234_5678);
        check("dbz_z",  bus.dbz, 1'b0);
`endif
        run_op(9, 3, -1, -1, 1'b0, d, s, r);
        check("q_9_3",   r[W-1:0], 3);
        check("dbz_clr", bus.dbz, 1'b0);

        // start re-pulsed while ITER shows iter=5
        run_op(100, 7, S0 + 6, -1, 1'b0, d, s, r);
        check("lat_repulse", d, LAT_100_7);
        check("q_repulse",   r[W-1:0], 14);

        // start held high for the whole operation, including DONE
        run_op(1000, 33, -1, -1, 1'b1, d, s, r);
        check("q_hold", r[W-1:0], 30);
        check("r_hold", r[2*W-1:W], 10);

        // reset while ITER shows iter=10, then a clean run
        run_op(100, 7, -1, S0 + 11, 1'b0, d, s, r);
        run_op(100, 7, -1, -1, 1'b0, d, s, r);
        check("lat_after_rst", d, LAT_100_7);
        check("q_after_rst",   r[W-1:0], 14);
        check("r_after_rst",   r[2*W-1:W], 2);

        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            if ($urandom_range(1, 0) == 1) b = $urandom_range(255, 1);
            else                           b = $urandom_range(32'h7FFF_FFFF, 1);
            run_op(a, b, -1, -1, 1'b0, d, s, r);
            check("lat_rand", d, LAT);
            check("shl_rand", s, W + 1);
            check("q_rand",   r[W-1:0], a / b);
            check("r_rand",   r[2*W-1:W], a % b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
